mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath. Sequences fetch/decode/execute/mem/writeback.
//  Drives every datapath select, including ExtOp, which picks sign or zero extension of the 16-bit immediate.
//  Stalls on a memory ready handshake. Sits beside the datapath top; its only datapath input is Zero.
// PARAMETERS
//  STATE_W     4  width of the state register and the State debug port
//  SUPPORT_BNE 1  1: bne is decoded; 0: bne is treated as an illegal opcode
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  synchronous, active-low reset
//  Opcode     in   6  IR[31:26]; sampled in DECODE
//  Zero       in   1  ALU zero flag, valid in BRANCH
//  MemReady   in   1  memory completes the current access this cycle
//  PCEn       out  1  PC load = PCWrite | (branch taken)
//  IorD       out  1  0: PC addresses memory; 1: ALUOut addresses memory
//  MemRead    out  1  memory read request, held until MemReady
//  MemWrite   out  1  memory write request, held until MemReady
//  IRWrite    out  1  load the instruction register
//  RegDst     out  1  0: rt; 1: rd
//  MemtoReg   out  1  0: ALUOut; 1: MDR
//  RegWrite   out  1  register file write enable
//  ALUSrcA    out  1  0: PC; 1: A
//  ALUSrcB    out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
//  ALUOp      out  2  00 add, 01 sub, 10 funct, 11 immediate logic (andi/ori via Opcode)
//  PCSource   out  2  00 ALU result, 01 ALUOut, 10 jump target
//  ExtOp      out  1  1: sign-extend imm; 0: zero-extend imm
//  Illegal    out  1  one-cycle pulse when DECODE sees an unsupported opcode
//  State      out  STATE_W  current state, debug only
// BEHAVIOUR
//  - Reset: rst_n=0 at a clk edge -> state FETCH. All enables (PCEn, MemRead, MemWrite, IRWrite, RegWrite,
//    Illegal) are 0 while rst_n=0. All selects and ExtOp are 0. rst_n has priority over every transition,
//    including an access in flight. After release the first FETCH cycle asserts MemRead.
//  - Outputs are a Moore decode of state. Exceptions: PCEn uses Zero in BRANCH; PCEn/IRWrite in FETCH are
//    gated by MemReady; Illegal is decoded from Opcode in DECODE.
//  - States and transitions (opcodes in hex):
//    FETCH   MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
//            When MemReady=1: IRWrite=1, PCEn=1, go to DECODE. Otherwise hold, with IRWrite=PCEn=0.
//    DECODE  ALUSrcA=0, ALUSrcB=11, ExtOp=1 (branch target into ALUOut). Next state by Opcode:
//            00->EXEC_R, 23/2B->MEMADR, 04->BRANCH, 05->BRANCH (SUPPORT_BNE), 08/0C/0D->EXEC_I,
//            02->JUMP, other->FETCH with Illegal=1.
//    MEMADR  ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUOp=00; 23->MEMRD, 2B->MEMWR
//    MEMRD   MemRead, IorD=1; hold until MemReady, then MEMWB
//    MEMWB   RegWrite, RegDst=0, MemtoReg=1 -> FETCH
//    MEMWR   MemWrite, IorD=1; hold until MemReady, then FETCH
//    EXEC_R  ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> WB_R
//    WB_R    RegWrite, RegDst=1, MemtoReg=0 -> FETCH
//    EXEC_I  ALUSrcA=1, ALUSrcB=10. ExtOp=1 for 08; ExtOp=0 for 0C/0D. ALUOp=00 for 08, 11 for 0C/0D -> WB_I
//    WB_I    RegWrite, RegDst=0, MemtoReg=0 -> FETCH
//    BRANCH  ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. PCEn=Zero for 04, PCEn=~Zero for 05 -> FETCH
//    JUMP    PCSource=10, PCEn=1 -> FETCH
//  - Opcode is captured into a 6-bit register in DECODE. Later states use the registered copy,
//    so an IR change after DECODE has no effect.
//  - MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.
//  - MemReady while not in FETCH/MEMRD/MEMWR is ignored. Unreachable state encodings -> FETCH.
//  - CPI: R/I-type 4, lw 5, sw 4, beq/bne 3, j 3 (zero memory wait). Each MemReady=0 cycle adds 1.
// STRUCTURE
//  - Package mips_ctrl_pkg: state encodings, opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
//    OP_ADDI, OP_ANDI, OP_ORI, OP_J), ALUSrcB/ALUOp/PCSource codes.
//  - Sub-module mips_ctrl_outdec: combinational state+opcode -> control word. The top holds only the
//    state register, the opcode register and next-state logic.
// TESTING
//  - Reset: hold rst_n=0 for 3 cycles, release -> State=FETCH, MemRead=1, all other enables 0.
//  - addi (08), MemReady=1 -> DECODE/EXEC_I/WB_I; ExtOp=1 in EXEC_I; RegWrite=1 for exactly 1 cycle; 4 cycles.
//  - ori (0D) -> ExtOp=0, ALUOp=11 in EXEC_I. lw (23) with MemReady low 2 cycles in MEMRD -> MemRead held; 7 cycles.
//  - beq (04): Zero=1 -> PCEn=1, PCSource=01 in BRANCH. Zero=0 -> PCEn=0. bne inverts both results.
//  - Opcode 3F in DECODE -> Illegal=1 for 1 cycle, next State=FETCH, no RegWrite or MemWrite.
//  - rst_n=0 during MEMWR with MemReady=0 -> MemWrite=0 in the same cycle; next State=FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS main control
// Purpose: state encodings, opcode values, datapath select codes and the control word.
// Ports: none (package).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_WB_R   = 4'd7,
        S_EXEC_I = 4'd8,
        S_WB_I   = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       ext_op;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op, input logic bne_en);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_legal = 1'b1;
            OP_BNE:                         op_legal = bne_en;
            default:                        op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// rtl/mips_ctrl_outdec.sv - combinational state/opcode to control word decode
// Purpose: Moore decode of the control word, plus the Zero/MemReady/Opcode exceptions.
// Ports: state_i current state, opcode_i live opcode in DECODE else registered copy,
//        zero_i ALU zero flag, mem_ready_i memory handshake, ctrl_o control word.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
#(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                // IR and PC only advance on the cycle the fetch completes
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_en     = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.ext_op    = 1'b1;
                ctrl_o.illegal   = ~op_legal(opcode_i, SUPPORT_BNE);
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.ext_op    = 1'b1;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_WB_R: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                // addi sign-extends and adds; andi/ori zero-extend and use the logic op
                ctrl_o.ext_op    = (opcode_i == OP_ADDI);
                ctrl_o.alu_op    = (opcode_i == OP_ADDI) ? ALUOP_ADD : ALUOP_IMM;
            end
            S_WB_I: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_source = PCSRC_ALUOUT;
                ctrl_o.pc_en     = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
            end
            S_JUMP: begin
                ctrl_o.pc_source = PCSRC_JUMP;
                ctrl_o.pc_en     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM for the multicycle MIPS datapath
// Purpose: state register, opcode register and next-state logic; outputs come from mips_ctrl_outdec.
// Ports: clk, rst_n (sync, active-low), Opcode, Zero, MemReady in;
//        PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//        ALUSrcB, ALUOp, PCSource, ExtOp, Illegal, State (debug) out.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W     = 4,
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Opcode,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCEn,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               ExtOp,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    state_e     state_q, state_d;
    logic [5:0] opc_q, opc_d;
    ctrl_t      ctrl, ctrl_g;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    // In DECODE the live opcode is both captured and used for decode; later
    // states see only the captured copy, so IR changes after DECODE are ignored.
    always_comb begin
        opc_d = (state_q == S_DECODE) ? Opcode : opc_q;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:                  state_d = S_EXEC_R;
                    OP_LW, OP_SW:              state_d = S_MEMADR;
                    OP_BEQ:                    state_d = S_BRANCH;
                    OP_BNE:                    state_d = SUPPORT_BNE ? S_BRANCH : S_FETCH;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_EXEC_I;
                    OP_J:                      state_d = S_JUMP;
                    default:                   state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opc_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            default:  state_d = S_FETCH;
        endcase
    end

    mips_ctrl_outdec #(
        .SUPPORT_BNE(SUPPORT_BNE)
    ) u_outdec (
        .state_i     (state_q),
        .opcode_i    (opc_d),
        .zero_i      (Zero),
        .mem_ready_i (MemReady),
        .ctrl_o      (ctrl)
    );

    // Reset forces every enable and select low immediately, even mid-access.
    always_comb begin
        ctrl_g = rst_n ? ctrl : '0;
    end

    assign PCEn     = ctrl_g.pc_en;
    assign IorD     = ctrl_g.iord;
    assign MemRead  = ctrl_g.mem_read;
    assign MemWrite = ctrl_g.mem_write;
    assign IRWrite  = ctrl_g.ir_write;
    assign RegDst   = ctrl_g.reg_dst;
    assign MemtoReg = ctrl_g.mem_to_reg;
    assign RegWrite = ctrl_g.reg_write;
    assign ALUSrcA  = ctrl_g.alu_src_a;
    assign ALUSrcB  = ctrl_g.alu_src_b;
    assign ALUOp    = ctrl_g.alu_op;
    assign PCSource = ctrl_g.pc_source;
    assign ExtOp    = ctrl_g.ext_op;
    assign Illegal  = ctrl_g.illegal;
    assign State    = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       ExtOp, Illegal;
    logic [3:0] State;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .ExtOp(ExtOp),
        .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        state_e st;
        logic   mr;
    } step_t;

    step_t plan[$];

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J};
    endfunction

    function automatic step_t mk(input state_e st, input logic mr);
        step_t s;
        s.st = st;
        s.mr = mr;
        return s;
    endfunction

    // Expected state walk of one instruction: fw fetch stalls, mw memory stalls.
    task automatic build_plan(input logic [5:0] op, input int fw, input int mw);
        plan.delete();
        for (int i = 0; i < fw; i++) plan.push_back(mk(S_FETCH, 1'b0));
        plan.push_back(mk(S_FETCH, 1'b1));
        plan.push_back(mk(S_DECODE, 1'($urandom)));
        case (op)
            OP_RTYPE: begin
                plan.push_back(mk(S_EXEC_R, 1'($urandom)));
                plan.push_back(mk(S_WB_R, 1'($urandom)));
            end
            OP_LW: begin
                plan.push_back(mk(S_MEMADR, 1'($urandom)));
                for (int i = 0; i < mw; i++) plan.push_back(mk(S_MEMRD, 1'b0));
                plan.push_back(mk(S_MEMRD, 1'b1));
                plan.push_back(mk(S_MEMWB, 1'($urandom)));
            end
            OP_SW: begin
                plan.push_back(mk(S_MEMADR, 1'($urandom)));
                for (int i = 0; i < mw; i++) plan.push_back(mk(S_MEMWR, 1'b0));
                plan.push_back(mk(S_MEMWR, 1'b1));
            end
            OP_BEQ, OP_BNE: plan.push_back(mk(S_BRANCH, 1'($urandom)));
            OP_ADDI, OP_ANDI, OP_ORI: begin
                plan.push_back(mk(S_EXEC_I, 1'($urandom)));
                plan.push_back(mk(S_WB_I, 1'($urandom)));
            end
            OP_J: plan.push_back(mk(S_JUMP, 1'($urandom)));
            default: ;
        endcase
    endtask

    // zv < 0: Zero random every cycle; otherwise Zero held at zv.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int zv);
        int n_rw = 0, n_mw = 0, n_mr = 0, n_pc = 0, n_ir = 0, n_il = 0;
        logic taken = 1'b0;
        logic t;
        logic [1:0] wb_exp;
        build_plan(op, fw, mw);
        wb_exp = (op == OP_RTYPE) ? 2'b10 : (op == OP_LW) ? 2'b01 : 2'b00;
        foreach (plan[k]) begin
            MemReady = plan[k].mr;
            Zero     = (zv < 0) ? 1'($urandom) : zv[0];
            Opcode   = (plan[k].st == S_DECODE) ? op : 6'($urandom);
            @(negedge clk);
            check("state", State, plan[k].st);
            check("rd_wr_excl", MemRead & MemWrite, 0);
            check("rw_mw_excl", RegWrite & MemWrite, 0);
            n_rw += RegWrite; n_mw += MemWrite; n_mr += MemRead;
            n_pc += PCEn; n_ir += IRWrite; n_il += Illegal;
            if (RegWrite) check("wb_sel", {RegDst, MemtoReg}, wb_exp);
            case (plan[k].st)
                S_FETCH: begin
                    check("fetch_irw", IRWrite, plan[k].mr);
                    check("fetch_pcen", PCEn, plan[k].mr);
                    check("fetch_sel", {IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource}, 8'b0_0_01_00_00);
                end
                S_DECODE: begin
                    check("dec_sel", {ALUSrcA, ALUSrcB, ExtOp}, 4'b0_11_1);
                    check("dec_illegal", Illegal, !is_legal(op));
                end
                S_MEMRD: check("memrd", {MemRead, IorD}, 2'b11);
                S_MEMWR: check("memwr", {MemWrite, IorD}, 2'b11);
                S_EXEC_I: begin
                    check("execi_src", {ALUSrcA, ALUSrcB}, 3'b1_10);
                    check("execi_ext_aluop", {ExtOp, ALUOp}, (op == OP_ADDI) ? 3'b1_00 : 3'b0_11);
                end
                S_BRANCH: begin
                    t = (op == OP_BEQ) ? Zero : ~Zero;
                    taken = t;
                    check("br_pcen", PCEn, t);
                    check("br_sel", {ALUOp, PCSource}, 4'b01_01);
                end
                S_JUMP: check("jump", {PCEn, PCSource}, 3'b1_10);
                default: ;
            endcase
            @(posedge clk);
            #1;
        end
        check("cnt_regwrite", n_rw, (op inside {OP_RTYPE, OP_LW, OP_ADDI, OP_ANDI, OP_ORI}) ? 1 : 0);
        check("cnt_memwrite", n_mw, (op == OP_SW) ? mw + 1 : 0);
        check("cnt_memread", n_mr, fw + 1 + ((op == OP_LW) ? mw + 1 : 0));
        check("cnt_pcen", n_pc, 1 + ((op == OP_J) ? 1 : 0) + (taken ? 1 : 0));
        check("cnt_irwrite", n_ir, 1);
        check("cnt_illegal", n_il, is_legal(op) ? 0 : 1);
    endtask

    logic [5:0] pool [11] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
                              OP_ANDI, OP_ORI, OP_J, 6'h3F, 6'h00};

    initial begin
        logic [5:0] op;
        rst_n = 1'b0; MemReady = 1'b1; Zero = 1'b0; Opcode = 6'h23;
        repeat (3) begin
            @(negedge clk);
            check("rst_enables", {PCEn, MemRead, MemWrite, IRWrite, RegWrite, Illegal}, 6'b0);
            check("rst_selects", {IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp}, 11'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; MemReady = 1'b0;
        @(negedge clk);
        check("post_rst_state", State, S_FETCH);
        check("post_rst_memread", MemRead, 1'b1);
        check("post_rst_enables", {PCEn, MemWrite, IRWrite, RegWrite, Illegal}, 5'b0);
        @(posedge clk); #1;

        run_instr(OP_ADDI, 0, 0, -1);
        run_instr(OP_ORI, 0, 0, -1);
        run_instr(OP_LW, 0, 2, -1);
        run_instr(OP_BEQ, 0, 0, 1);
        run_instr(OP_BEQ, 0, 0, 0);
        run_instr(OP_BNE, 0, 0, 1);
        run_instr(OP_BNE, 0, 0, 0);
        run_instr(6'h3F, 0, 0, -1);
        run_instr(OP_SW, 1, 1, -1);
        run_instr(OP_J, 0, 0, -1);
        run_instr(OP_RTYPE, 2, 0, -1);
        run_instr(OP_ANDI, 0, 0, -1);

        for (int n = 0; n < 150; n++) begin
            op = pool[$urandom_range(0, 10)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end

        // Reset arriving while a store is stalled in MEMWR.
        MemReady = 1'b1; Opcode = 6'h11;
        @(negedge clk); check("abort_fetch", State, S_FETCH);
        @(posedge clk); #1;
        Opcode = OP_SW; MemReady = 1'b0;
        @(negedge clk); check("abort_decode", State, S_DECODE);
        @(posedge clk); #1;
        Opcode = 6'h23;
        @(negedge clk); check("abort_memadr", State, S_MEMADR);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_memwr", State, S_MEMWR);
        check("abort_memwrite_on", MemWrite, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_memwrite_off", MemWrite, 1'b0);
        @(posedge clk); #1;
        check("abort_next_state", State, S_FETCH);
        rst_n = 1'b1;
        run_instr(OP_LW, 0, 1, -1);
        run_instr(OP_ADDI, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
